pci_target_ready_ctrl: RTL and testbench
========================================

// Module: pci_target_ready_ctrl
// PURPOSE
//  Parametrised PCI target data-phase controller. It drives TRDY# and STOP# for a claimed
//  transaction, with programmable initial and subsequent wait states, a storage-ready gate,
//  burst phase counting and target disconnect after MAX_BURST phases.
//  Sits between the DEVSEL# decode and the storage/data-path block of the PCI slave.
// PARAMETERS
//  INIT_WAIT    2  wait cycles from claim to first TRDY# assertion (0..15)
//  SUBSEQ_WAIT  0  wait cycles inserted after each completed data phase (0..15)
//  MAX_BURST    8  data phases before disconnect-with-STOP#; 0 = unlimited
//  CNT_W        4  width of phase_cnt; must hold MAX_BURST
// PORTS
//  clk            in   1      bus clock; all state updates on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  frame_n        in   1      FRAME#, active low
//  irdy_n         in   1      IRDY#, active low
//  devsel_n       in   1      DEVSEL# from decode, active low (target claimed)
//  storage_rdy    in   1      1 = storage can source/sink one data phase
//  trdy_n         out  1      TRDY#, active low, registered
//  stop_n         out  1      STOP#, active low, registered
//  xfer_stb       out  1      1-cycle pulse: data phase completed (IRDY#&TRDY# low at edge)
//  phase_cnt      out  CNT_W  completed phases in current transaction, saturating
//  busy           out  1      1 when FSM not IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, trdy_n=1, stop_n=1, xfer_stb=0, phase_cnt=0, busy=0.
//  All outputs registered; the values below are the values after the named edge.
//  IDLE:  devsel_n=0 sampled -> phase_cnt:=0, wait_cnt:=INIT_WAIT;
//         go READY if INIT_WAIT=0 && storage_rdy, else WAIT.
//  WAIT:  trdy_n=1. wait_cnt>1 -> decrement. wait_cnt<=1 && storage_rdy -> READY (trdy_n:=0).
//         wait_cnt<=1 && !storage_rdy -> hold. Net effect: N wait cycles exactly when storage is ready.
//  READY: trdy_n=0. It stays low until a transfer occurs; storage_rdy is ignored once asserted.
//         Transfer = irdy_n=0 && trdy_n=0 at edge -> xfer_stb:=1, phase_cnt:=phase_cnt+1, then:
//           frame_n=1 (last phase)             -> TURN
//           MAX_BURST!=0 && new cnt=MAX_BURST  -> DISCON
//           SUBSEQ_WAIT>0 || !storage_rdy      -> WAIT, wait_cnt:=SUBSEQ_WAIT
//           else                               -> stay READY (zero-wait burst)
//  DISCON: trdy_n=1, stop_n=0. Hold until frame_n=1 is sampled, then -> TURN.
//  TURN:  trdy_n=1, stop_n=1 for exactly one cycle, then -> IDLE.
//  Abort: devsel_n=1 sampled in WAIT/READY/DISCON -> IDLE next edge, outputs deasserted.
//         Higher priority than a simultaneous transfer; xfer_stb=0 in that case.
//  Master abort: frame_n=1 && irdy_n=1 in WAIT -> IDLE.
//  phase_cnt saturates at all-ones. It is cleared only on a new claim or on reset.
//  trdy_n and stop_n are never both low. TRDY# never deasserts without a transfer, except on abort/reset.
//  Reset mid-transfer: outputs return to inactive immediately (asynchronous), FSM -> IDLE.
// STRUCTURE
//  Package pci_tgt_pkg holds:
//    - state encoding localparams (IDLE, WAIT, READY, DISCON, TURN)
//    - the 4-bit wait-counter width
//    - the active-low ASSERTED=0 / DEASSERTED=1 constants.
//  Sub-module pci_wait_cnt: loadable down-counter with load value and a "done" flag (cnt<=1).
//  Everything else stays in one FSM always block plus the output registers.
// TESTING
//  1. INIT_WAIT=2, storage_rdy=1, devsel_n low at edge 0, irdy_n low
//     -> trdy_n low after edge 2; xfer_stb after edge 3.
//  2. INIT_WAIT=0, SUBSEQ_WAIT=0, 4-phase burst, frame_n high on 4th phase
//     -> 4 back-to-back xfer_stb, phase_cnt=4, TURN, then IDLE.
//  3. MAX_BURST=3 with a continuous burst
//     -> after 3rd xfer_stb: stop_n=0, trdy_n=1 until frame_n=1, then both high.
//  4. storage_rdy=0 for 5 cycles after the wait expires
//     -> trdy_n stays 1, asserts the edge after storage_rdy=1.
//     Then drop storage_rdy while in READY -> trdy_n stays 0.
//  5. irdy_n held high in READY for 4 cycles
//     -> trdy_n stays low, no xfer_stb. devsel_n high -> IDLE, trdy_n=1.
//  6. rst_n pulled low during READY
//     -> trdy_n=1, stop_n=1, phase_cnt=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pci_tgt_pkg.sv
// Shared definitions for the PCI target data-phase controller.
//   WAIT_W              width of the wait-state down-counter
//   ASSERTED/DEASSERTED levels of the active-low PCI control pins
//   S_* / tgt_state_e   FSM state encoding
package pci_tgt_pkg;

    localparam int WAIT_W = 4;

    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_DISCON = 3'd3;
    localparam logic [2:0] S_TURN   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_WAIT   = S_WAIT,
        ST_READY  = S_READY,
        ST_DISCON = S_DISCON,
        ST_TURN   = S_TURN
    } tgt_state_e;

endpackage

// File: rtl/pci_wait_cnt.sv
// Loadable wait-state down-counter.
// Ports:
//   clk       bus clock
//   rst_n     asynchronous active-low reset
//   load      load load_val (has priority over dec)
//   load_val  value to load
//   dec       count down by one while above 1
//   done      1 when the count is 0 or 1, i.e. the last wait cycle is in progress
module pci_wait_cnt
    import pci_tgt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              done
);

    localparam logic [WAIT_W-1:0] ONE = WAIT_W'(1);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt > ONE)) begin
            cnt <= cnt - ONE;
        end
    end

    // Exiting on cnt<=1 (rather than 0) makes a load of N give exactly N wait cycles.
    assign done = (cnt <= ONE);

endmodule

// File: rtl/pci_target_ready_ctrl.sv
// PCI target data-phase controller: drives TRDY#/STOP# for a claimed transaction,
// with programmable initial/subsequent wait states, a storage-ready gate, burst phase
// counting and disconnect after MAX_BURST phases.
// Ports:
//   clk          bus clock
//   rst_n        asynchronous active-low reset
//   frame_n      FRAME#, active low
//   irdy_n       IRDY#, active low
//   devsel_n     DEVSEL# from decode, active low (target claimed)
//   storage_rdy  storage can source/sink one data phase
//   trdy_n       TRDY#, registered
//   stop_n       STOP#, registered
//   xfer_stb     one-cycle pulse per completed data phase
//   phase_cnt    completed phases in the current transaction, saturating
//   busy         FSM not idle
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no claim; outputs inactive
// WAIT    | counting wait states / waiting for storage_rdy, TRDY# high
// READY   | TRDY# low until IRDY# completes the data phase
// DISCON  | burst limit reached, STOP# low until the master drops FRAME#
// TURN    | one turnaround cycle with TRDY#/STOP# high
module pci_target_ready_ctrl
    import pci_tgt_pkg::*;
#(
    parameter int INIT_WAIT   = 2,
    parameter int SUBSEQ_WAIT = 0,
    parameter int MAX_BURST   = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_n,
    input  logic             irdy_n,
    input  logic             devsel_n,
    input  logic             storage_rdy,
    output logic             trdy_n,
    output logic             stop_n,
    output logic             xfer_stb,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             busy
);

    localparam logic [WAIT_W-1:0] INIT_LD   = WAIT_W'(INIT_WAIT);
    localparam logic [WAIT_W-1:0] SUBSEQ_LD = WAIT_W'(SUBSEQ_WAIT);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    tgt_state_e        state;
    logic              claim;
    logic              xfer;
    logic              wc_load;
    logic              wc_dec;
    logic              wc_done;
    logic [WAIT_W-1:0] wc_val;
    logic [CNT_W-1:0]  cnt_next;

    assign claim = (state == ST_IDLE) && (devsel_n == ASSERTED);

    // A deasserted DEVSEL# masks the transfer so an abort wins over a data phase.
    assign xfer = (state == ST_READY) && (devsel_n == ASSERTED) &&
                  (irdy_n == ASSERTED) && (trdy_n == ASSERTED);

    // Reloading on every transfer is harmless when the FSM stays in READY.
    assign wc_load = claim || xfer;
    assign wc_val  = claim ? INIT_LD : SUBSEQ_LD;
    assign wc_dec  = (state == ST_WAIT);

    assign cnt_next = (phase_cnt == CNT_SAT) ? phase_cnt : phase_cnt + CNT_ONE;

    pci_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wc_load),
        .load_val (wc_val),
        .dec      (wc_dec),
        .done     (wc_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            trdy_n    <= DEASSERTED;
            stop_n    <= DEASSERTED;
            xfer_stb  <= 1'b0;
            phase_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            xfer_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (claim) begin
                        phase_cnt <= '0;
                        busy      <= 1'b1;
                        if ((INIT_WAIT == 0) && storage_rdy) begin
                            state  <= ST_READY;
                            trdy_n <= ASSERTED;
                        end else begin
                            state  <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if ((devsel_n == DEASSERTED) ||
                        ((frame_n == DEASSERTED) && (irdy_n == DEASSERTED))) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        trdy_n <= DEASSERTED;
                        stop_n <= DEASSERTED;
                    end else if (wc_done && storage_rdy) begin
                        state  <= ST_READY;
                        trdy_n <= ASSERTED;
                    end
                end

                ST_READY: begin
                    if (devsel_n == DEASSERTED) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        trdy_n <= DEASSERTED;
                        stop_n <= DEASSERTED;
                    end else if (xfer) begin
                        xfer_stb  <= 1'b1;
                        phase_cnt <= cnt_next;
                        if (frame_n == DEASSERTED) begin
                            state  <= ST_TURN;
                            trdy_n <= DEASSERTED;
                        end else if ((MAX_BURST != 0) && (cnt_next == MAX_CNT)) begin
                            state  <= ST_DISCON;
                            trdy_n <= DEASSERTED;
                            stop_n <= ASSERTED;
                        end else if ((SUBSEQ_WAIT != 0) || !storage_rdy) begin
                            state  <= ST_WAIT;
                            trdy_n <= DEASSERTED;
                        end
                    end
                end

                ST_DISCON: begin
                    if (devsel_n == DEASSERTED) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        trdy_n <= DEASSERTED;
                        stop_n <= DEASSERTED;
                    end else if (frame_n == DEASSERTED) begin
                        state  <= ST_TURN;
                        stop_n <= DEASSERTED;
                    end
                end

                ST_TURN: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    trdy_n <= DEASSERTED;
                    stop_n <= DEASSERTED;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    trdy_n <= DEASSERTED;
                    stop_n <= DEASSERTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_target_ready_ctrl.sv
// Directed bench for pci_target_ready_ctrl. Three instances share the bus inputs:
//   dut_a: INIT_WAIT=2, SUBSEQ_WAIT=1, MAX_BURST=8
//   dut_b: INIT_WAIT=0, SUBSEQ_WAIT=0, MAX_BURST=0 (unlimited)
//   dut_c: INIT_WAIT=0, SUBSEQ_WAIT=0, MAX_BURST=3
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// "edge k" below is the k-th rising edge after the claim is presented.
module tb_pci_target_ready_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_n = 1'b1;
    logic irdy_n = 1'b1;
    logic devsel_n = 1'b1;
    logic storage_rdy = 1'b1;

    logic       a_trdy_n, a_stop_n, a_xfer, a_busy;
    logic [3:0] a_cnt;
    logic       b_trdy_n, b_stop_n, b_xfer, b_busy;
    logic [3:0] b_cnt;
    logic       c_trdy_n, c_stop_n, c_xfer, c_busy;
    logic [3:0] c_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pci_target_ready_ctrl #(.INIT_WAIT(2), .SUBSEQ_WAIT(1), .MAX_BURST(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .devsel_n(devsel_n),
        .storage_rdy(storage_rdy), .trdy_n(a_trdy_n), .stop_n(a_stop_n), .xfer_stb(a_xfer),
        .phase_cnt(a_cnt), .busy(a_busy));

    pci_target_ready_ctrl #(.INIT_WAIT(0), .SUBSEQ_WAIT(0), .MAX_BURST(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .devsel_n(devsel_n),
        .storage_rdy(storage_rdy), .trdy_n(b_trdy_n), .stop_n(b_stop_n), .xfer_stb(b_xfer),
        .phase_cnt(b_cnt), .busy(b_busy));

    pci_target_ready_ctrl #(.INIT_WAIT(0), .SUBSEQ_WAIT(0), .MAX_BURST(3), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .devsel_n(devsel_n),
        .storage_rdy(storage_rdy), .trdy_n(c_trdy_n), .stop_n(c_stop_n), .xfer_stb(c_xfer),
        .phase_cnt(c_cnt), .busy(c_busy));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        frame_n = 1'b1; irdy_n = 1'b1; devsel_n = 1'b1; storage_rdy = 1'b1;
    endtask

    task automatic do_reset;
        bus_idle();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++; if (a_trdy_n !== 1'b1) begin n_err++; $display("FAIL rst_a_trdy got %b exp 1", a_trdy_n); end
        n_vec++; if (a_stop_n !== 1'b1) begin n_err++; $display("FAIL rst_a_stop got %b exp 1", a_stop_n); end
        n_vec++; if (a_xfer !== 1'b0) begin n_err++; $display("FAIL rst_a_xfer got %b exp 0", a_xfer); end
        n_vec++; if (a_cnt !== 4'd0) begin n_err++; $display("FAIL rst_a_cnt got %0d exp 0", a_cnt); end
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_a_busy got %b exp 0", a_busy); end
        n_vec++; if (b_trdy_n !== 1'b1) begin n_err++; $display("FAIL rst_b_trdy got %b exp 1", b_trdy_n); end
        n_vec++; if (c_stop_n !== 1'b1) begin n_err++; $display("FAIL rst_c_stop got %b exp 1", c_stop_n); end
        // no claim: stays idle
        tick();
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL idle_a_busy got %b exp 0", a_busy); end
    endtask

    // dut_a: claim at edge 0, TRDY# after edge 2, single phase at edge 3.
    task automatic test_init_wait;
        do_reset();
        devsel_n = 1'b0; frame_n = 1'b0; irdy_n = 1'b0;
        tick(); // edge 0
        n_vec++; if (a_trdy_n !== 1'b1) begin n_err++; $display("FAIL iw_e0_trdy got %b exp 1", a_trdy_n); end
        n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL iw_e0_busy got %b exp 1", a_busy); end
        tick(); // edge 1
        n_vec++; if (a_trdy_n !== 1'b1) begin n_err++; $display("FAIL iw_e1_trdy got %b exp 1", a_trdy_n); end
        tick(); // edge 2
        n_vec++; if (a_trdy_n !== 1'b0) begin n_err++; $display("FAIL iw_e2_trdy got %b exp 0", a_trdy_n); end
        n_vec++; if (a_xfer !== 1'b0) begin n_err++; $display("FAIL iw_e2_xfer got %b exp 0", a_xfer); end
        frame_n = 1'b1;
        tick(); // edge 3: last phase
        n_vec++; if (a_xfer !== 1'b1) begin n_err++; $display("FAIL iw_e3_xfer got %b exp 1", a_xfer); end
        n_vec++; if (a_cnt !== 4'd1) begin n_err++; $display("FAIL iw_e3_cnt got %0d exp 1", a_cnt); end
        n_vec++; if (a_trdy_n !== 1'b1) begin n_err++; $display("FAIL iw_e3_trdy got %b exp 1", a_trdy_n); end
        n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL iw_e3_busy got %b exp 1", a_busy); end
        devsel_n = 1'b1; irdy_n = 1'b1;
        tick(); // edge 4: TURN -> IDLE
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL iw_e4_busy got %b exp 0", a_busy); end
        n_vec++; if (a_xfer !== 1'b0) begin n_err++; $display("FAIL iw_e4_xfer got %b exp 0", a_xfer); end
    endtask

    // dut_a: one subsequent wait cycle between phases.
    task automatic test_subseq_wait;
        do_reset();
        devsel_n = 1'b0; frame_n = 1'b0; irdy_n = 1'b0;
        tick(); tick(); tick(); // edges 0..2 -> READY
        tick(); // edge 3: first phase, SUBSEQ_WAIT=1 -> WAIT
        n_vec++; if (a_xfer !== 1'b1) begin n_err++; $display("FAIL sw_e3_xfer got %b exp 1", a_xfer); end
        n_vec++; if (a_trdy_n !== 1'b1) begin n_err++; $display("FAIL sw_e3_trdy got %b exp 1", a_trdy_n); end
        tick(); // edge 4: one wait cycle done
        n_vec++; if (a_trdy_n !== 1'b0) begin n_err++; $display("FAIL sw_e4_trdy got %b exp 0", a_trdy_n); end
        n_vec++; if (a_xfer !== 1'b0) begin n_err++; $display("FAIL sw_e4_xfer got %b exp 0", a_xfer); end
        frame_n = 1'b1;
        tick(); // edge 5: last phase
        n_vec++; if (a_cnt !== 4'd2) begin n_err++; $display("FAIL sw_e5_cnt got %0d exp 2", a_cnt); end
        n_vec++; if (a_xfer !== 1'b1) begin n_err++; $display("FAIL sw_e5_xfer got %b exp 1", a_xfer); end
        bus_idle();
        tick(); tick();
    endtask

    // dut_a: master abort while waiting.
    task automatic test_master_abort;
        do_reset();
        devsel_n = 1'b0; frame_n = 1'b0; irdy_n = 1'b1;
        tick(); // edge 0: WAIT
        n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL ma_e0_busy got %b exp 1", a_busy); end
        frame_n = 1'b1;
        tick(); // edge 1: FRAME#/IRDY# both high -> IDLE
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL ma_e1_busy got %b exp 0", a_busy); end
        n_vec++; if (a_trdy_n !== 1'b1) begin n_err++; $display("FAIL ma_e1_trdy got %b exp 1", a_trdy_n); end
        bus_idle();
        tick();
    endtask

    // dut_b: 4-phase zero-wait burst.
    task automatic test_back_to_back;
        do_reset();
        devsel_n = 1'b0; frame_n = 1'b0; irdy_n = 1'b0;
        tick(); // edge 0: straight to READY
        n_vec++; if (b_trdy_n !== 1'b0) begin n_err++; $display("FAIL bb_e0_trdy got %b exp 0", b_trdy_n); end
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) frame_n = 1'b1;
            tick();
            n_vec++; if (b_xfer !== 1'b1) begin n_err++; $display("FAIL bb_xfer phase %0d got %b exp 1", k, b_xfer); end
            n_vec++; if (b_cnt !== 4'(k)) begin n_err++; $display("FAIL bb_cnt phase %0d got %0d exp %0d", k, b_cnt, k); end
            n_vec++; if (b_trdy_n !== ((k == 4) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL bb_trdy phase %0d got %b exp %b", k, b_trdy_n, (k == 4)); end
        end
        n_vec++; if (b_busy !== 1'b1) begin n_err++; $display("FAIL bb_turn_busy got %b exp 1", b_busy); end
        n_vec++; if (b_stop_n !== 1'b1) begin n_err++; $display("FAIL bb_turn_stop got %b exp 1", b_stop_n); end
        bus_idle();
        tick(); // TURN -> IDLE
        n_vec++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL bb_idle_busy got %b exp 0", b_busy); end
        n_vec++; if (b_xfer !== 1'b0) begin n_err++; $display("FAIL bb_idle_xfer got %b exp 0", b_xfer); end
    endtask

    // dut_b: 17 phases, phase_cnt saturates at 15 and is cleared only by a new claim.
    task automatic test_saturate;
        logic [3:0] exp_cnt;
        do_reset();
        devsel_n = 1'b0; frame_n = 1'b0; irdy_n = 1'b0;
        tick(); // edge 0
        for (int k = 1; k <= 17; k++) begin
            if (k == 17) frame_n = 1'b1;
            tick();
            exp_cnt = (k > 15) ? 4'd15 : 4'(k);
            n_vec++; if (b_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_cnt phase %0d got %0d exp %0d", k, b_cnt, exp_cnt); end
        end
        bus_idle();
        tick(); tick();
        n_vec++; if (b_cnt !== 4'd15) begin n_err++; $display("FAIL sat_hold_idle got %0d exp 15", b_cnt); end
        devsel_n = 1'b0; frame_n = 1'b0;
        tick(); // new claim clears
        n_vec++; if (b_cnt !== 4'd0) begin n_err++; $display("FAIL sat_clear_claim got %0d exp 0", b_cnt); end
        bus_idle();
        tick(); tick();
    endtask

    // dut_c: disconnect after 3 phases.
    task automatic test_disconnect;
        do_reset();
        devsel_n = 1'b0; frame_n = 1'b0; irdy_n = 1'b0;
        tick(); // edge 0
        tick(); tick(); // phases 1, 2
        n_vec++; if (c_stop_n !== 1'b1) begin n_err++; $display("FAIL dc_p2_stop got %b exp 1", c_stop_n); end
        tick(); // phase 3
        n_vec++; if (c_xfer !== 1'b1) begin n_err++; $display("FAIL dc_p3_xfer got %b exp 1", c_xfer); end
        n_vec++; if (c_cnt !== 4'd3) begin n_err++; $display("FAIL dc_p3_cnt got %0d exp 3", c_cnt); end
        n_vec++; if (c_stop_n !== 1'b0) begin n_err++; $display("FAIL dc_p3_stop got %b exp 0", c_stop_n); end
        n_vec++; if (c_trdy_n !== 1'b1) begin n_err++; $display("FAIL dc_p3_trdy got %b exp 1", c_trdy_n); end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++; if (c_stop_n !== 1'b0) begin n_err++; $display("FAIL dc_hold_stop cyc %0d got %b exp 0", k, c_stop_n); end
            n_vec++; if (c_trdy_n !== 1'b1) begin n_err++; $display("FAIL dc_hold_trdy cyc %0d got %b exp 1", k, c_trdy_n); end
            n_vec++; if (c_xfer !== 1'b0) begin n_err++; $display("FAIL dc_hold_xfer cyc %0d got %b exp 0", k, c_xfer); end
        end
        frame_n = 1'b1;
        tick(); // TURN
        n_vec++; if (c_stop_n !== 1'b1) begin n_err++; $display("FAIL dc_turn_stop got %b exp 1", c_stop_n); end
        n_vec++; if (c_trdy_n !== 1'b1) begin n_err++; $display("FAIL dc_turn_trdy got %b exp 1", c_trdy_n); end
        n_vec++; if (c_busy !== 1'b1) begin n_err++; $display("FAIL dc_turn_busy got %b exp 1", c_busy); end
        bus_idle();
        tick();
        n_vec++; if (c_busy !== 1'b0) begin n_err++; $display("FAIL dc_idle_busy got %b exp 0", c_busy); end
    endtask

    // dut_a: storage gate after the wait expires, then storage_rdy ignored in READY.
    task automatic test_storage_gate;
        do_reset();
        devsel_n = 1'b0; frame_n = 1'b0; irdy_n = 1'b1;
        tick(); tick(); // edges 0, 1
        storage_rdy = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            tick();
            n_vec++; if (a_trdy_n !== 1'b1) begin n_err++; $display("FAIL sg_gate edge %0d got %b exp 1", k, a_trdy_n); end
        end
        storage_rdy = 1'b1;
        tick(); // edge 7
        n_vec++; if (a_trdy_n !== 1'b0) begin n_err++; $display("FAIL sg_release got %b exp 0", a_trdy_n); end
        storage_rdy = 1'b0;
        for (int k = 8; k <= 9; k++) begin
            tick();
            n_vec++; if (a_trdy_n !== 1'b0) begin n_err++; $display("FAIL sg_ready_hold edge %0d got %b exp 0", k, a_trdy_n); end
        end
        bus_idle();
        tick();
        n_vec++; if (a_trdy_n !== 1'b1) begin n_err++; $display("FAIL sg_abort_trdy got %b exp 1", a_trdy_n); end
    endtask

    // dut_b: IRDY# stall in READY, then abort coinciding with IRDY# assertion.
    task automatic test_irdy_stall_abort;
        do_reset();
        devsel_n = 1'b0; frame_n = 1'b0; irdy_n = 1'b1;
        tick(); // edge 0: READY
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++; if (b_trdy_n !== 1'b0) begin n_err++; $display("FAIL st_trdy cyc %0d got %b exp 0", k, b_trdy_n); end
            n_vec++; if (b_xfer !== 1'b0) begin n_err++; $display("FAIL st_xfer cyc %0d got %b exp 0", k, b_xfer); end
        end
        devsel_n = 1'b1; irdy_n = 1'b0;
        tick();
        n_vec++; if (b_trdy_n !== 1'b1) begin n_err++; $display("FAIL ab_trdy got %b exp 1", b_trdy_n); end
        n_vec++; if (b_xfer !== 1'b0) begin n_err++; $display("FAIL ab_xfer got %b exp 0", b_xfer); end
        n_vec++; if (b_cnt !== 4'd0) begin n_err++; $display("FAIL ab_cnt got %0d exp 0", b_cnt); end
        n_vec++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL ab_busy got %b exp 0", b_busy); end
        bus_idle();
        tick();
    endtask

    // dut_b: asynchronous reset in READY, checked between clock edges.
    task automatic test_async_reset;
        do_reset();
        devsel_n = 1'b0; frame_n = 1'b0; irdy_n = 1'b0;
        tick(); tick(); // edge 0 READY, edge 1 first phase
        n_vec++; if (b_cnt !== 4'd1) begin n_err++; $display("FAIL ar_pre_cnt got %0d exp 1", b_cnt); end
        n_vec++; if (b_trdy_n !== 1'b0) begin n_err++; $display("FAIL ar_pre_trdy got %b exp 0", b_trdy_n); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (b_trdy_n !== 1'b1) begin n_err++; $display("FAIL ar_trdy got %b exp 1", b_trdy_n); end
        n_vec++; if (b_stop_n !== 1'b1) begin n_err++; $display("FAIL ar_stop got %b exp 1", b_stop_n); end
        n_vec++; if (b_cnt !== 4'd0) begin n_err++; $display("FAIL ar_cnt got %0d exp 0", b_cnt); end
        n_vec++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got %b exp 0", b_busy); end
        bus_idle();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_init_wait();
        test_subseq_wait();
        test_master_abort();
        test_back_to_back();
        test_saturate();
        test_disconnect();
        test_storage_gate();
        test_irdy_stall_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
